// File: rtl/ex_stage_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_muldiv_if
//  Description : ID/EX -> EX/MEM bundle for the execute stage (operands,
//                forwarding, handshake and registered result).
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_stage_muldiv_if #(
    parameter int DATA_W  = 32,
    parameter int FW_SRCS = 4
);
    localparam int c_SEL_W = (FW_SRCS > 1) ? $clog2(FW_SRCS) : 1;
    localparam int c_SH_W  = $clog2(DATA_W);

    logic                          valid_in;
    logic                          ready_out;
    logic [3:0]                    op;
    logic [DATA_W-1:0]             rf_rd1;
    logic [DATA_W-1:0]             rf_rd2;
    logic [(FW_SRCS-1)*DATA_W-1:0] fw_bus;
    logic [c_SEL_W-1:0]            fw_sel_a;
    logic [c_SEL_W-1:0]            fw_sel_b;
    logic                          alu_src;
    logic [DATA_W-1:0]             imm;
    logic [c_SH_W-1:0]             shamt;
    logic [4:0]                    reg_dest_in;
    logic                          reg_write_in;
    logic                          stall_in;
    logic                          valid_out;
    logic [DATA_W-1:0]             alu_result;
    logic [DATA_W-1:0]             store_data;
    logic [4:0]                    reg_dest_out;
    logic                          reg_write_out;

    // Pipeline side: drives the instruction and the downstream stall.
    modport master (
        output valid_in, op, rf_rd1, rf_rd2, fw_bus, fw_sel_a, fw_sel_b,
               alu_src, imm, shamt, reg_dest_in, reg_write_in, stall_in,
        input  ready_out, valid_out, alu_result, store_data, reg_dest_out,
               reg_write_out
    );

    // Execute stage side.
    modport slave (
        input  valid_in, op, rf_rd1, rf_rd2, fw_bus, fw_sel_a, fw_sel_b,
               alu_src, imm, shamt, reg_dest_in, reg_write_in, stall_in,
        output ready_out, valid_out, alu_result, store_data, reg_dest_out,
               reg_write_out
    );
endinterface
`default_nettype wire

// File: rtl/ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_muldiv
//  Description : Execute stage with operand forwarding, single-cycle ALU,
//                fixed-latency multiplier, radix-2 restoring divider and an
//                architectural HI/LO pair, feeding a registered EX/MEM output.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_stage_muldiv #(
    parameter int DATA_W  = 32,
    parameter int FW_SRCS = 4,
    parameter int MUL_LAT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ex_stage_muldiv_if.slave  bus
);
    localparam int c_SEL_W   = (FW_SRCS > 1) ? $clog2(FW_SRCS) : 1;
    localparam int c_CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [3:0] c_OP_ADD  = 4'd0,  c_OP_SUB   = 4'd1,  c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3,  c_OP_XOR   = 4'd4,  c_OP_SLT  = 4'd5;
    localparam logic [3:0] c_OP_SLL  = 4'd6,  c_OP_SRL   = 4'd7,  c_OP_MULT = 4'd8;
    localparam logic [3:0] c_OP_MULTU= 4'd9,  c_OP_DIV   = 4'd10, c_OP_DIVU = 4'd11;
    localparam logic [3:0] c_OP_MFHI = 4'd12, c_OP_MFLO  = 4'd13, c_OP_MTHI = 4'd14;
    localparam logic [3:0] c_OP_MTLO = 4'd15;

    localparam logic [1:0] c_S_IDLE = 2'd0, c_S_MUL = 2'd1, c_S_DIV = 2'd2, c_S_DONE = 2'd3;

    logic [1:0]          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_hi, r_lo;
    logic [2*DATA_W-1:0] r_prod;
    logic [DATA_W-1:0]   r_rem, r_quo, r_dvs, r_dvd_raw;
    logic                r_neg_q, r_neg_r, r_div0;
    logic                r_valid_out, r_reg_write_out;
    logic [DATA_W-1:0]   r_alu_result, r_store_data;
    logic [4:0]          r_reg_dest_out;

    logic [DATA_W-1:0]   w_opa, w_opb, w_opb_alu, w_alu;
    logic                w_accept, w_ready, w_is_mul, w_is_div, w_no_wb;
    logic                w_mul_done, w_div_done;
    logic [2*DATA_W-1:0] w_ma, w_mb, w_prod;
    logic                w_neg_a, w_neg_b;
    logic [DATA_W:0]     w_shift, w_diff;
    logic [DATA_W-1:0]   w_rem_nxt, w_quo_nxt, w_q_fin, w_r_fin;

    assign w_ready  = (r_state == c_S_IDLE) && !bus.stall_in;
    assign w_accept = bus.valid_in && w_ready;
    assign w_is_mul = (bus.op == c_OP_MULT) || (bus.op == c_OP_MULTU);
    assign w_is_div = (bus.op == c_OP_DIV)  || (bus.op == c_OP_DIVU);
    assign w_no_wb  = w_is_mul || w_is_div || (bus.op == c_OP_MTHI) || (bus.op == c_OP_MTLO);

    // Forwarding muxes: select 0 is the register file, select i is FwBus slice i-1.
    always_comb begin
        w_opa = bus.rf_rd1;
        w_opb = bus.rf_rd2;
        for (int i = 1; i < FW_SRCS; i++) begin
            if (bus.fw_sel_a == c_SEL_W'(i)) w_opa = bus.fw_bus[(i-1)*DATA_W +: DATA_W];
            if (bus.fw_sel_b == c_SEL_W'(i)) w_opb = bus.fw_bus[(i-1)*DATA_W +: DATA_W];
        end
    end

    assign w_opb_alu = bus.alu_src ? bus.imm : w_opb;

    // Single-cycle ALU; MTHI/MTLO pass operand A through as their result.
    always_comb begin
        w_alu = '0;
        case (bus.op)
            c_OP_ADD:  w_alu = w_opa + w_opb_alu;
            c_OP_SUB:  w_alu = w_opa - w_opb_alu;
            c_OP_AND:  w_alu = w_opa & w_opb_alu;
            c_OP_OR:   w_alu = w_opa | w_opb_alu;
            c_OP_XOR:  w_alu = w_opa ^ w_opb_alu;
            c_OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_opa) < $signed(w_opb_alu))};
            c_OP_SLL:  w_alu = w_opb_alu << bus.shamt;
            c_OP_SRL:  w_alu = w_opb_alu >> bus.shamt;
            c_OP_MFHI: w_alu = r_hi;
            c_OP_MFLO: w_alu = r_lo;
            c_OP_MTHI: w_alu = w_opa;
            c_OP_MTLO: w_alu = w_opa;
            default:   w_alu = '0;
        endcase
    end

    // Product is formed at accept and held until the latency counter expires;
    // sign-extending to 2*DATA_W makes the truncated product correct for MULT.
    assign w_neg_a = (bus.op == c_OP_DIV) && w_opa[DATA_W-1];
    assign w_neg_b = (bus.op == c_OP_DIV) && w_opb[DATA_W-1];
    assign w_ma    = {{DATA_W{(bus.op == c_OP_MULT) && w_opa[DATA_W-1]}}, w_opa};
    assign w_mb    = {{DATA_W{(bus.op == c_OP_MULT) && w_opb[DATA_W-1]}}, w_opb};
    assign w_prod  = w_ma * w_mb;

    // One restoring step on magnitudes; the dividend shifts out of r_quo MSB first.
    assign w_shift   = {r_rem, r_quo[DATA_W-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_rem_nxt = w_diff[DATA_W] ? w_shift[DATA_W-1:0] : w_diff[DATA_W-1:0];
    assign w_quo_nxt = {r_quo[DATA_W-2:0], ~w_diff[DATA_W]};
    assign w_q_fin   = r_div0 ? '1        : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
    assign w_r_fin   = r_div0 ? r_dvd_raw : (r_neg_r ? -w_rem_nxt : w_rem_nxt);

    assign w_mul_done = (r_state == c_S_MUL) && (r_cnt == c_CNT_W'(MUL_LAT - 1));
    assign w_div_done = (r_state == c_S_DIV) && (r_cnt == c_CNT_W'(DATA_W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: a finished MULT/DIV parks in DONE while MEM is stalled.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept && w_is_mul)      w_state_nxt = c_S_MUL;
                else if (w_accept && w_is_div) w_state_nxt = c_S_DIV;
            end
            c_S_MUL:  if (w_mul_done) w_state_nxt = bus.stall_in ? c_S_DONE : c_S_IDLE;
            c_S_DIV:  if (w_div_done) w_state_nxt = bus.stall_in ? c_S_DONE : c_S_IDLE;
            c_S_DONE: if (!bus.stall_in) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Multi-cycle datapath and HI/LO; HI/LO are written once, on the completion edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0; r_hi <= '0; r_lo <= '0; r_prod <= '0;
            r_rem <= '0; r_quo <= '0; r_dvs <= '0; r_dvd_raw <= '0;
            r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_div0 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_prod    <= w_prod;
                r_rem     <= '0;
                r_quo     <= w_neg_a ? -w_opa : w_opa;
                r_dvs     <= w_neg_b ? -w_opb : w_opb;
                r_dvd_raw <= w_opa;
                r_neg_q   <= w_neg_a ^ w_neg_b;
                r_neg_r   <= w_neg_a;
                r_div0    <= (w_opb == '0);
                if (bus.op == c_OP_MTHI) r_hi <= w_opa;
                if (bus.op == c_OP_MTLO) r_lo <= w_opa;
            end else if (r_state == c_S_MUL || r_state == c_S_DIV) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == c_S_DIV) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end
            if (w_mul_done) {r_hi, r_lo} <= r_prod;
            if (w_div_done) begin
                r_hi <= w_r_fin;
                r_lo <= w_q_fin;
            end
        end
    end

    // EX/MEM register: holds under stall, emits MULT/DIV results as LO with no writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_out <= 1'b0; r_reg_write_out <= 1'b0; r_alu_result <= '0;
            r_store_data <= '0; r_reg_dest_out <= '0;
        end else if (!bus.stall_in) begin
            if (w_accept) begin
                r_valid_out     <= !(w_is_mul || w_is_div);
                r_alu_result    <= w_alu;
                r_store_data    <= w_opb;
                r_reg_dest_out  <= bus.reg_dest_in;
                r_reg_write_out <= bus.reg_write_in && !w_no_wb;
            end else if (w_mul_done) begin
                r_valid_out <= 1'b1; r_alu_result <= r_prod[DATA_W-1:0]; r_reg_write_out <= 1'b0;
            end else if (w_div_done) begin
                r_valid_out <= 1'b1; r_alu_result <= w_q_fin; r_reg_write_out <= 1'b0;
            end else if (r_state == c_S_DONE) begin
                r_valid_out <= 1'b1; r_alu_result <= r_lo; r_reg_write_out <= 1'b0;
            end else begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign bus.ready_out     = w_ready;
    assign bus.valid_out     = r_valid_out;
    assign bus.alu_result    = r_alu_result;
    assign bus.store_data    = r_store_data;
    assign bus.reg_dest_out  = r_reg_dest_out;
    assign bus.reg_write_out = r_reg_write_out;
endmodule
`default_nettype wire

// File: tb/tb_ex_stage_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage_muldiv
//  Description : Self-checking bench for ex_stage_muldiv: directed vector
//                table, stall/back-pressure/reset sequences and randomized
//                instructions against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_stage_muldiv;
    localparam int c_DW  = 32;
    localparam int c_LAT = 4;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rf1, rf2, imm;
        logic        alu_src;
        logic [4:0]  shamt;
        logic [1:0]  sa, sb;
        logic [4:0]  dest;
        logic        rw;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fwv [3];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          errors = 0, checks = 0;
    vec_t        tbl [28];

    ex_stage_muldiv_if #(.DATA_W(c_DW), .FW_SRCS(4)) bus ();
    ex_stage_muldiv #(.DATA_W(c_DW), .FW_SRCS(4), .MUL_LAT(c_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    assign bus.fw_bus = {fwv[2], fwv[1], fwv[0]};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rf1, rf2, imm,
                                input logic alu_src, input logic [4:0] shamt,
                                input logic [1:0] sa, sb, input logic [31:0] exp);
        vec_t v;
        v.op = op; v.rf1 = rf1; v.rf2 = rf2; v.imm = imm; v.alu_src = alu_src;
        v.shamt = shamt; v.sa = sa; v.sb = sb; v.dest = 5'd3; v.rw = 1'b1; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.op = v.op; bus.rf_rd1 = v.rf1; bus.rf_rd2 = v.rf2; bus.imm = v.imm;
        bus.alu_src = v.alu_src; bus.shamt = v.shamt; bus.fw_sel_a = v.sa;
        bus.fw_sel_b = v.sb; bus.reg_dest_in = v.dest; bus.reg_write_in = v.rw;
    endtask

    // Issue one instruction, wait for its result and compare with the model
    // (or with the vector's own expected value when use_exp is set).
    task automatic run_op(input vec_t v, input bit use_exp, input string tag);
        logic [31:0] a, bf, ba, res;
        logic [63:0] p, qv, rv;
        longint      x, y;
        int          lat, n;
        bit          multi;
        a  = (v.sa == 0) ? v.rf1 : fwv[v.sa-1];
        bf = (v.sb == 0) ? v.rf2 : fwv[v.sb-1];
        ba = v.alu_src ? v.imm : bf;
        lat = 0; multi = 0; res = '0;
        case (v.op)
            4'd0:  res = a + ba;
            4'd1:  res = a - ba;
            4'd2:  res = a & ba;
            4'd3:  res = a | ba;
            4'd4:  res = a ^ ba;
            4'd5:  res = ($signed(a) < $signed(ba)) ? 32'd1 : 32'd0;
            4'd6:  res = ba << v.shamt;
            4'd7:  res = ba >> v.shamt;
            4'd8:  begin
                x = longint'($signed(a)); y = longint'($signed(bf)); p = x * y;
                m_hi = p[63:32]; m_lo = p[31:0]; lat = c_LAT; multi = 1;
            end
            4'd9:  begin
                p = {32'd0, a} * {32'd0, bf};
                m_hi = p[63:32]; m_lo = p[31:0]; lat = c_LAT; multi = 1;
            end
            4'd10: begin
                if (bf == 0) begin m_lo = '1; m_hi = a; end
                else begin
                    x = longint'($signed(a)); y = longint'($signed(bf));
                    qv = x / y; rv = x % y; m_lo = qv[31:0]; m_hi = rv[31:0];
                end
                lat = c_DW; multi = 1;
            end
            4'd11: begin
                if (bf == 0) begin m_lo = '1; m_hi = a; end
                else begin m_lo = a / bf; m_hi = a % bf; end
                lat = c_DW; multi = 1;
            end
            4'd12: res = m_hi;
            4'd13: res = m_lo;
            4'd14: begin m_hi = a; res = a; end
            default: begin m_lo = a; res = a; end
        endcase
        if (multi) res = m_lo;
        if (use_exp) res = v.exp;

        drive(v);
        bus.valid_in = 1'b1;
        n = 0;
        while (!bus.ready_out && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) check({tag, " ready_timeout"}, 64'(bus.ready_out), 64'd1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        if (multi) begin
            n = 0;
            while (!bus.ready_out && n < 100) begin @(posedge clk); #1; n++; end
            check({tag, " busy_cycles"}, 64'(n), 64'(lat));
        end
        check({tag, " valid"}, 64'(bus.valid_out), 64'd1);
        check({tag, " result"}, 64'(bus.alu_result), 64'(res));
        check({tag, " regwrite"}, 64'(bus.reg_write_out),
              64'(v.rw && !(v.op inside {4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd15})));
        check({tag, " dest"}, 64'(bus.reg_dest_out), 64'(v.dest));
        check({tag, " store"}, 64'(bus.store_data), 64'(bf));
    endtask

    initial begin
        vec_t v;
        int   n;

        tbl[0]  = mk(4'd0,  32'h0,        32'h5,        32'h0,        0, 5'd0,  2'd2, 2'd0, 32'h15);
        tbl[1]  = mk(4'd1,  32'h3,        32'h5,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFE);
        tbl[2]  = mk(4'd0,  32'hFFFF_FFFF,32'h1,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h0);
        tbl[3]  = mk(4'd2,  32'hF0F0_1234,32'h0,        32'h0FF0_FFFF,1, 5'd0,  2'd0, 2'd0, 32'h00F0_1234);
        tbl[4]  = mk(4'd3,  32'h1200,     32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd3, 32'h3000_1200);
        tbl[5]  = mk(4'd4,  32'h0,        32'hFFFF,     32'h0,        0, 5'd0,  2'd1, 2'd0, 32'h5F5F);
        tbl[6]  = mk(4'd5,  32'hFFFF_FFFF,32'h1,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h1);
        tbl[7]  = mk(4'd5,  32'h1,        32'hFFFF_FFFF,32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h0);
        tbl[8]  = mk(4'd5,  32'h8000_0000,32'h7FFF_FFFF,32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h1);
        tbl[9]  = mk(4'd6,  32'h0,        32'h1,        32'h0,        0, 5'd31, 2'd0, 2'd0, 32'h8000_0000);
        tbl[10] = mk(4'd7,  32'h0,        32'h8000_0000,32'h0,        0, 5'd31, 2'd0, 2'd0, 32'h1);
        tbl[11] = mk(4'd14, 32'hDEAD_BEEF,32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hDEAD_BEEF);
        tbl[12] = mk(4'd12, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hDEAD_BEEF);
        tbl[13] = mk(4'd15, 32'h1234,     32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h1234);
        tbl[14] = mk(4'd13, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h1234);
        tbl[15] = mk(4'd8,  32'hFFFF_FFFF,32'h2,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFE);
        tbl[16] = mk(4'd12, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFF);
        tbl[17] = mk(4'd13, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFE);
        tbl[18] = mk(4'd9,  32'hFFFF_FFFF,32'h2,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFE);
        tbl[19] = mk(4'd12, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h1);
        tbl[20] = mk(4'd10, 32'hFFFF_FFF9,32'h2,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFD);
        tbl[21] = mk(4'd12, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFF);
        tbl[22] = mk(4'd11, 32'h9,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFF);
        tbl[23] = mk(4'd12, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h9);
        tbl[24] = mk(4'd10, 32'h8000_0000,32'hFFFF_FFFF,32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h8000_0000);
        tbl[25] = mk(4'd12, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'h0);
        tbl[26] = mk(4'd10, 32'hFFFF_FFF8,32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFFF);
        tbl[27] = mk(4'd12, 32'h0,        32'h0,        32'h0,        0, 5'd0,  2'd0, 2'd0, 32'hFFFF_FFF8);

        fwv[0] = 32'h0000_A0A0; fwv[1] = 32'h0000_0010; fwv[2] = 32'h3000_0000;
        bus.valid_in = 1'b0; bus.stall_in = 1'b0;
        drive(mk(4'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(bus.ready_out), 64'd1);
        check("reset valid", 64'(bus.valid_out), 64'd0);
        check("reset result", 64'(bus.alu_result), 64'd0);
        check("reset store", 64'(bus.store_data), 64'd0);
        check("reset dest", 64'(bus.reg_dest_out), 64'd0);
        check("reset regwrite", 64'(bus.reg_write_out), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle valid", 64'(bus.valid_out), 64'd0);

        // Directed vectors.
        for (int i = 0; i < 28; i++) run_op(tbl[i], 1'b1, $sformatf("vec%0d", i));
        m_hi = 32'hFFFF_FFF8; m_lo = 32'hFFFF_FFFF;

        // Single-cycle result holds under stall; a waiting instruction is not taken.
        run_op(mk(4'd0, 32'h0F, 32'hF0, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'hFF), 1'b1, "pre_stall");
        bus.stall_in = 1'b1;
        drive(mk(4'd4, 32'hFF, 32'h0F, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0));
        bus.valid_in = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("stall hold valid", 64'(bus.valid_out), 64'd1);
            check("stall hold result", 64'(bus.alu_result), 64'hFF);
            check("stall ready", 64'(bus.ready_out), 64'd0);
        end
        bus.stall_in = 1'b0; #1;
        check("unstall ready", 64'(bus.ready_out), 64'd1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        check("after stall result", 64'(bus.alu_result), 64'hF0);
        check("after stall valid", 64'(bus.valid_out), 64'd1);

        // MULT completes under stall: parks in DONE, result pulses after release.
        drive(mk(4'd8, 32'd3, 32'd5, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0));
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        m_hi = 32'h0; m_lo = 32'd15;
        repeat (3) begin
            check("mul busy ready", 64'(bus.ready_out), 64'd0);
            check("mul busy valid", 64'(bus.valid_out), 64'd0);
            @(posedge clk); #1;
        end
        bus.stall_in = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("done stall valid", 64'(bus.valid_out), 64'd0);
            check("done stall ready", 64'(bus.ready_out), 64'd0);
        end
        bus.stall_in = 1'b0; #1;
        check("done ready", 64'(bus.ready_out), 64'd0);
        @(posedge clk); #1;
        check("done pulse valid", 64'(bus.valid_out), 64'd1);
        check("done pulse result", 64'(bus.alu_result), 64'd15);
        check("done pulse regwrite", 64'(bus.reg_write_out), 64'd0);
        check("done exit ready", 64'(bus.ready_out), 64'd1);
        @(posedge clk); #1;
        check("done pulse once", 64'(bus.valid_out), 64'd0);
        run_op(mk(4'd12, 32'h0, 32'h0, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0), 1'b1, "done mfhi");
        run_op(mk(4'd13, 32'h0, 32'h0, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'd15), 1'b1, "done mflo");

        // ADD held on Valid_In through a MULT is taken once, when Ready_Out returns.
        drive(mk(4'd8, 32'd6, 32'd7, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0));
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        m_hi = 32'h0; m_lo = 32'd42;
        drive(mk(4'd0, 32'd1, 32'd2, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0));
        n = 0;
        while (!bus.ready_out && n < 100) begin @(posedge clk); #1; n++; end
        check("held busy cycles", 64'(n), 64'(c_LAT));
        check("held mul result", 64'(bus.alu_result), 64'd42);
        check("held mul valid", 64'(bus.valid_out), 64'd1);
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        check("held add result", 64'(bus.alu_result), 64'd3);
        check("held add valid", 64'(bus.valid_out), 64'd1);
        check("held add regwrite", 64'(bus.reg_write_out), 64'd1);
        @(posedge clk); #1;
        check("held add once", 64'(bus.valid_out), 64'd0);

        // Reset in the middle of a divide aborts it and clears HI/LO.
        drive(mk(4'd11, 32'd100, 32'd7, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0));
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("abort ready", 64'(bus.ready_out), 64'd1);
        check("abort valid", 64'(bus.valid_out), 64'd0);
        check("abort result", 64'(bus.alu_result), 64'd0);
        m_hi = 32'h0; m_lo = 32'h0;
        run_op(mk(4'd12, 32'h0, 32'h0, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0), 1'b1, "abort mfhi");
        run_op(mk(4'd13, 32'h0, 32'h0, 32'h0, 0, 5'd0, 2'd0, 2'd0, 32'h0), 1'b1, "abort mflo");

        // Randomized instructions against the reference model.
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 3; j++) fwv[j] = $urandom;
            v.op = 4'($urandom_range(0, 15));
            v.rf1 = $urandom; v.rf2 = $urandom; v.imm = $urandom;
            v.alu_src = 1'($urandom_range(0, 1));
            v.shamt = 5'($urandom_range(0, 31));
            v.sa = 2'($urandom_range(0, 3)); v.sb = 2'($urandom_range(0, 3));
            v.dest = 5'($urandom_range(0, 31)); v.rw = 1'($urandom_range(0, 1));
            v.exp = '0;
            if ($urandom_range(0, 3) == 0) v.rf2 = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) begin v.rf2 = '0; v.sb = 2'd0; end
            run_op(v, 1'b0, $sformatf("rand%0d op%0d", i, v.op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
